// File: rtl/div_arbiter_pkg.sv
// div_arbiter_pkg: FSM encoding and sizing helpers shared by
// the round-robin divider scheduler and its picker.
package div_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotate the request vector by the pointer, take the
// lowest set bit, then rotate the index back.
module rr_picker
    import div_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [IW-1:0]      grant_o,
    output logic               any_o
);

    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0]      hit;

    always_comb begin
        logic [IW-1:0] j;
        j   = '0;
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j      = IW'((int'(ptr_i) + i) % NUM_REQ);
            rot[i] = req_i[j];
        end
    end

    // Descending scan so the lowest rotated position wins.
    always_comb begin
        hit = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) hit = IW'(i);
        end
    end

    assign grant_o = IW'((int'(hit) + int'(ptr_i)) % NUM_REQ);
    assign any_o   = |req_i;

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one divider among NUM_REQ requesters with
// round-robin grants, one-cycle responses and a watchdog.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int MAX_LATENCY    = 80
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DIVIDEND_WIDTH-1:0]         rsp_quotient,
    output logic [DIVISOR_WIDTH-1:0]          rsp_remainder,
    output logic                              rsp_overflow,
    output logic                              rsp_timeout,
    output logic                              busy,
    output logic                              div_valid_in,
    output logic [DIVIDEND_WIDTH-1:0]         div_dividend,
    output logic [DIVISOR_WIDTH-1:0]          div_divisor,
    output logic                              div_reset,
    input  logic [DIVIDEND_WIDTH-1:0]         div_quotient,
    input  logic [DIVISOR_WIDTH-1:0]          div_remainder,
    input  logic                              div_overflow,
    input  logic                              div_valid_out
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = $clog2(MAX_LATENCY + 1);

    state_t                    state_q, state_d;
    logic [IW-1:0]             ptr_q, ptr_d;
    logic [IW-1:0]             gnt_q, gnt_d;
    logic [DIVIDEND_WIDTH-1:0] dvd_q, dvd_d;
    logic [DIVISOR_WIDTH-1:0]  dvs_q, dvs_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DIVIDEND_WIDTH-1:0] quo_q, quo_d;
    logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
    logic                      ovf_q, ovf_d;
    logic                      tmo_q, tmo_d;
    logic                      drst_q, drst_d;

    logic [IW-1:0] pick;
    logic          any_req;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick),
        .any_o   (any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            drst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            drst_q  <= drst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        drst_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = pick;
                    dvd_d   = req_dividend[int'(pick)*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
                    dvs_d   = req_divisor[int'(pick)*DIVISOR_WIDTH +: DIVISOR_WIDTH];
                    tmo_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A completion in the final watchdog cycle still wins.
                if (div_valid_out) begin
                    quo_d   = div_quotient;
                    rem_d   = div_remainder;
                    ovf_d   = div_overflow;
                    state_d = RESPOND;
                end else if (cnt_q == CW'(MAX_LATENCY - 1)) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b1;
                    drst_d  = 1'b1;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                ptr_d   = (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + IW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        rsp_valid    = '0;
        busy         = 1'b0;
        div_valid_in = 1'b0;
        if (!reset) begin
            busy         = (state_q != IDLE);
            div_valid_in = (state_q == ISSUE);
            if (state_q == IDLE && any_req) req_ready[pick] = 1'b1;
            if (state_q == RESPOND) rsp_valid[gnt_q] = 1'b1;
        end
    end

    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_overflow  = ovf_q;
    assign rsp_timeout   = tmo_q;
    assign div_dividend  = dvd_q;
    assign div_divisor   = dvs_q;
    assign div_reset     = drst_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed and random transactions against a
// behavioural divider and a queue-free round-robin reference.
module tb_div_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int VW = 32;
    localparam int ML = 80;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_dividend;
    logic [N*VW-1:0]   req_divisor;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_quotient;
    logic [VW-1:0]     rsp_remainder;
    logic              rsp_overflow;
    logic              rsp_timeout;
    logic              busy;
    logic              div_valid_in;
    logic [DW-1:0]     div_dividend;
    logic [VW-1:0]     div_divisor;
    logic              div_reset;
    logic [DW-1:0]     div_quotient;
    logic [VW-1:0]     div_remainder;
    logic              div_overflow;
    logic              div_valid_out;

    logic [DW-1:0] a_m [N];
    logic [VW-1:0] b_m [N];
    int            lat;
    bit            hang;
    bit            spur;
    int            ptr_m;
    int            cyc;
    int            n_assert;
    int            n_fail;

    logic mvo;
    int   dcnt;
    bit   dact;

    div_arbiter #(
        .NUM_REQ        (N),
        .DIVIDEND_WIDTH (DW),
        .DIVISOR_WIDTH  (VW),
        .MAX_LATENCY    (ML)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_overflow  (rsp_overflow),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy),
        .div_valid_in  (div_valid_in),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_reset     (div_reset),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_overflow  (div_overflow),
        .div_valid_out (div_valid_out)
    );

    assign req_dividend  = {a_m[3], a_m[2], a_m[1], a_m[0]};
    assign req_divisor   = {b_m[3], b_m[2], b_m[1], b_m[0]};
    assign div_valid_out = mvo | spur;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider: result appears lat cycles after start.
    always @(posedge clk) begin
        mvo <= 1'b0;
        if (reset || div_reset) begin
            dact <= 1'b0;
        end else if (div_valid_in) begin
            dact <= 1'b1;
            dcnt <= 1;
        end else if (dact) begin
            if (!hang && dcnt == lat - 1) begin
                mvo  <= 1'b1;
                dact <= 1'b0;
                if (div_divisor == '0) begin
                    div_quotient  <= '1;
                    div_remainder <= div_dividend[VW-1:0];
                    div_overflow  <= 1'b1;
                end else begin
                    div_quotient  <= div_dividend / {32'd0, div_divisor};
                    div_remainder <= VW'(div_dividend % {32'd0, div_divisor});
                    div_overflow  <= 1'b0;
                end
            end
            dcnt <= dcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_rsp"}, rsp_valid, 0);
        chk({tag, "_issue"}, div_valid_in, 0);
        chk({tag, "_dreset"}, div_reset, 0);
        chk({tag, "_dvd"}, div_dividend, 0);
        chk({tag, "_dvs"}, div_divisor, 0);
        chk({tag, "_quo"}, rsp_quotient, 0);
        chk({tag, "_rem"}, rsp_remainder, 0);
        chk({tag, "_ovf"}, rsp_overflow, 0);
        chk({tag, "_tmo"}, rsp_timeout, 0);
    endtask

    task automatic do_reset(input int ncyc);
        reset     = 1'b1;
        req_valid = '0;
        repeat (ncyc) step();
        chk_quiet("rst");
        reset = 1'b0;
        ptr_m = 0;
        step();
    endtask

    task automatic serve(input logic [N-1:0] mask, input bit hold);
        int            g;
        int            t0;
        int            dr_at;
        int            n;
        int            elat;
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic          eo;
        logic          et;
        g = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask[(ptr_m + k) % N]) g = (ptr_m + k) % N;
        end
        et = hang || (lat > ML);
        if (et) begin
            eq = '0; er = '0; eo = 1'b0; elat = ML + 2;
        end else if (b_m[g] == '0) begin
            eq = '1; er = a_m[g][VW-1:0]; eo = 1'b1; elat = lat + 2;
        end else begin
            eq = a_m[g] / {32'd0, b_m[g]};
            er = VW'(a_m[g] % {32'd0, b_m[g]});
            eo = 1'b0;
            elat = lat + 2;
        end
        req_valid = mask;
        #1;
        for (n = 0; n < 200 && req_ready == '0; n++) step();
        chk("ready_onehot", 64'($countones(req_ready)), 1);
        chk("grant", req_ready, 64'(1) << g);
        chk("no_issue_at_accept", div_valid_in, 0);
        t0 = cyc;
        step();
        if (!hold) req_valid[g] = 1'b0;
        chk("issue", div_valid_in, 1);
        chk("opnd_a", div_dividend, a_m[g]);
        chk("opnd_b", div_divisor, b_m[g]);
        chk("busy", busy, 1);
        dr_at = -1;
        for (n = 0; n < 300; n++) begin
            if (div_reset && dr_at < 0) dr_at = cyc - t0;
            if (rsp_valid != '0) break;
            chk("no_grant_busy", req_ready, 0);
            if (n > 0) chk("issue_once", div_valid_in, 0);
            chk("opnd_hold", div_dividend, a_m[g]);
            step();
        end
        chk("rsp_valid", rsp_valid, 64'(1) << g);
        chk("rsp_latency", 64'(cyc - t0), 64'(elat));
        chk("quotient", rsp_quotient, eq);
        chk("remainder", rsp_remainder, er);
        chk("overflow", rsp_overflow, eo);
        chk("timeout", rsp_timeout, et);
        chk("div_reset_at", 64'(dr_at), et ? 64'(ML + 2) : '1);
        ptr_m = (g + 1) % N;
        step();
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("div_reset_one", div_reset, 0);
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        req_valid = '0;
        spur      = 1'b0;
        hang      = 1'b0;
        lat       = 10;
        cyc       = 0;
        n_assert  = 0;
        n_fail    = 0;
        ptr_m     = 0;
        for (int i = 0; i < N; i++) begin
            a_m[i] = '0;
            b_m[i] = '0;
        end
        do_reset(3);
        chk_quiet("idle");

        a_m[1] = 100; b_m[1] = 7;
        serve(4'b0010, 1'b0);

        do_reset(1);
        for (int i = 0; i < N; i++) begin
            a_m[i] = 64'(1000 + 17 * i);
            b_m[i] = 32'(3 + i);
        end
        repeat (5) serve(4'b1111, 1'b1);
        req_valid = '0;

        serve(4'b0100, 1'b0);
        serve(4'b0101, 1'b0);
        req_valid = '0;

        a_m[3] = 12345; b_m[3] = 0;
        serve(4'b1000, 1'b0);
        a_m[0] = 100; b_m[0] = 7;
        serve(4'b0001, 1'b0);

        hang = 1'b1;
        a_m[2] = 555; b_m[2] = 5;
        serve(4'b0100, 1'b0);
        hang = 1'b0;
        a_m[1] = 100; b_m[1] = 7;
        serve(4'b0010, 1'b0);

        lat = ML;
        a_m[0] = 64'hdead_beef_0123_4567; b_m[0] = 32'h1234;
        serve(4'b0001, 1'b0);
        lat = ML + 1;
        serve(4'b0001, 1'b0);
        lat = 10;

        req_valid = '0;
        spur = 1'b1;
        step();
        spur = 1'b0;
        chk("spur_busy", busy, 0);
        chk("spur_rsp", rsp_valid, 0);
        step();
        chk("spur_rsp2", rsp_valid, 0);

        a_m[1] = 9; b_m[1] = 3;
        serve(4'b0010, 1'b0);
        a_m[3] = 77; b_m[3] = 7;
        lat = 20;
        req_valid = 4'b1000;
        #1;
        chk("mid_grant", req_ready, 4'b1000);
        step();
        req_valid = '0;
        repeat (5) step();
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        ptr_m = 0;
        chk_quiet("mid_rst");
        for (int i = 0; i < 30; i++) begin
            step();
            chk("mid_no_rsp", rsp_valid, 0);
        end
        a_m[0] = 100; b_m[0] = 7;
        a_m[2] = 50;  b_m[2] = 6;
        lat = 10;
        serve(4'b0101, 1'b0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                a_m[i] = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) b_m[i] = '0;
                else if ($urandom_range(0, 1) == 0) b_m[i] = 32'($urandom_range(1, 1000));
                else b_m[i] = $urandom;
            end
            lat = $urandom_range(2, 30);
            serve(4'($urandom_range(1, 15)), 1'b0);
        end
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
